// File: rtl/superpixel_draw_arbiter.sv
// superpixel_draw_arbiter
//   Shares one superpixel drawer between two requesters with round-robin
//   fairness. Each accepted command is issued as a one-cycle dvld pulse, and
//   no further command is taken until the drawer returns ddone.
//
//   Ports:
//     clk, rst                 clock (rising edge), async active-low reset
//     req0/x0/y0/data0, ack0   port-0 request (level) with payload, ack pulse
//     req1/x1/y1/data1, ack1   port-1 request (level) with payload, ack pulse
//     dx/dy/ddata, dvld        registered command to drawer, one-cycle valid
//     ddone                    drawer completion pulse
//     busy                     high while a command is outstanding
//     grant_id                 port of the current/last issued command
//     timeout                  one-cycle watchdog pulse
//
//   Optional build macro: DRAW_ARB_TIMEOUT_EN
//     Adds a WAIT-state watchdog: after TIMEOUT_CYCLES cycles in WAIT with
//     no ddone, the arbiter returns to IDLE and pulses timeout. Without the
//     macro timeout is tied low and WAIT exits only on ddone.

module superpixel_draw_arbiter #(
    parameter int          SPIXEL_X_WIDTH = 6,
    parameter int          SPIXEL_Y_WIDTH = 6,
    parameter int          COLOR_ID_WIDTH = 8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8192
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0,
    input  logic [SPIXEL_X_WIDTH-1:0] x0,
    input  logic [SPIXEL_Y_WIDTH-1:0] y0,
    input  logic [COLOR_ID_WIDTH-1:0] data0,
    output logic                      ack0,
    input  logic                      req1,
    input  logic [SPIXEL_X_WIDTH-1:0] x1,
    input  logic [SPIXEL_Y_WIDTH-1:0] y1,
    input  logic [COLOR_ID_WIDTH-1:0] data1,
    output logic                      ack1,
    output logic [SPIXEL_X_WIDTH-1:0] dx,
    output logic [SPIXEL_Y_WIDTH-1:0] dy,
    output logic [COLOR_ID_WIDTH-1:0] ddata,
    output logic                      dvld,
    input  logic                      ddone,
    output logic                      busy,
    output logic                      grant_id,
    output logic                      timeout
);

    // state   | meaning
    // --------+------------------------------------------------------------
    // ST_IDLE | no command outstanding; requests are sampled every edge
    // ST_WAIT | command issued to drawer; waiting for ddone (or watchdog)

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                    state_q, state_d;
    logic [SPIXEL_X_WIDTH-1:0] dx_q, dx_d;
    logic [SPIXEL_Y_WIDTH-1:0] dy_q, dy_d;
    logic [COLOR_ID_WIDTH-1:0] ddata_q, ddata_d;
    logic                      dvld_q, dvld_d;
    logic                      ack0_q, ack0_d;
    logic                      ack1_q, ack1_d;
    logic                      grant_q, grant_d;
    // Port that wins when both request; flips away from each completed grant.
    logic                      pref_q, pref_d;
    logic                      sel;
`ifdef DRAW_ARB_TIMEOUT_EN
    logic [15:0]               cnt_q, cnt_d;
    logic                      timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        ddata_d = ddata_q;
        dvld_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        grant_d = grant_q;
        pref_d  = pref_q;
        sel     = 1'b0;
`ifdef DRAW_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    sel = (req0 && req1) ? pref_q : req1;
                    if (sel) begin
                        dx_d    = x1;
                        dy_d    = y1;
                        ddata_d = data1;
                        ack1_d  = 1'b1;
                    end else begin
                        dx_d    = x0;
                        dy_d    = y0;
                        ddata_d = data0;
                        ack0_d  = 1'b1;
                    end
                    dvld_d  = 1'b1;
                    grant_d = sel;
                    state_d = ST_WAIT;
`ifdef DRAW_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                // dvld_q marks the first WAIT cycle; a ddone there cannot
                // belong to the command just issued.
                if (ddone && !dvld_q) begin
                    state_d = ST_IDLE;
                    pref_d  = ~grant_q;
                end
`ifdef DRAW_ARB_TIMEOUT_EN
                else if (cnt_q + 16'd1 == TIMEOUT_CYCLES) begin
                    state_d   = ST_IDLE;
                    pref_d    = ~grant_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            dx_q      <= '0;
            dy_q      <= '0;
            ddata_q   <= '0;
            dvld_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            grant_q   <= 1'b0;
            pref_q    <= 1'b0;
`ifdef DRAW_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            ddata_q   <= ddata_d;
            dvld_q    <= dvld_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            grant_q   <= grant_d;
            pref_q    <= pref_d;
`ifdef DRAW_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign dx       = dx_q;
    assign dy       = dy_q;
    assign ddata    = ddata_q;
    assign dvld     = dvld_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == ST_WAIT);
`ifdef DRAW_ARB_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: doc/superpixel_draw_arbiter.md
Name: superpixel_draw_arbiter

Overview:
- Shares the single superpixel drawer between two requesters, for example game logic on port 0 and the overlay/text engine on port 1.
- Accepts one draw command (superpixel x, y, colour id) per request/ack handshake and issues it to the drawer as a one-cycle valid pulse.
- Holds off further commands until the drawer's done pulse returns.
- Round-robin fairness between the two ports.

Parameters:
- SPIXEL_X_WIDTH, 6, superpixel x coordinate width
- SPIXEL_Y_WIDTH, 6, superpixel y coordinate width
- COLOR_ID_WIDTH, 8, colour id width
- TIMEOUT_CYCLES, 16'd8192, WAIT-state watchdog limit (optional feature only); counter width 16

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- req0  in  1  port-0 draw request; level, held with payload until ack0
- x0  in  SPIXEL_X_WIDTH  port-0 superpixel x
- y0  in  SPIXEL_Y_WIDTH  port-0 superpixel y
- data0  in  COLOR_ID_WIDTH  port-0 colour id
- ack0  out  1  one-cycle pulse: port-0 command taken
- req1, x1, y1, data1, ack1  same as port 0, for port 1
- dx  out  SPIXEL_X_WIDTH  drawer x
- dy  out  SPIXEL_Y_WIDTH  drawer y
- ddata  out  COLOR_ID_WIDTH  drawer colour id
- dvld  out  1  one-cycle command valid to drawer
- ddone  in  1  drawer completion pulse
- busy  out  1  high while not IDLE
- grant_id  out  1  port of the current/last issued command
- timeout  out  1  one-cycle watchdog pulse; constant 0 when the feature is off

Behaviour:
- Reset (rst=0, async): state=IDLE, ack0=ack1=dvld=0, dx=dy=ddata=0, grant_id=0, busy=0, timeout=0, rr pointer = port 0 preferred.
- All outputs are registered.
- States: IDLE, WAIT.
- IDLE, on an edge with req0 or req1 high:
  - Select port i: if only one requests, that port; if both, the port not granted last (after reset: port 0).
  - Register dx/dy/ddata from port i; dvld=1, ack_i=1, grant_id=i; go to WAIT.
- Latency: req sampled high at edge N gives ack_i, dvld and the payload valid during cycle N+1.
- dvld and ack are single-cycle pulses, cleared on the next edge.
- dx/dy/ddata hold their value until the next grant.
- WAIT, ddone handling:
  - ddone is ignored in the first WAIT cycle (the cycle dvld is high).
  - ddone=1 on any later WAIT edge: return to IDLE; the rr pointer records grant_id.
- Back-to-back: ddone at edge M puts the FSM in IDLE during cycle M+1. A pending request is granted at edge M+1, so the next dvld is high in cycle M+2.
- ddone while in IDLE: ignored, no state change.
- Request withdrawal:
  - Requests are sampled only at IDLE edges.
  - Dropping req before ack is legal; nothing is issued.
  - req held high after ack counts as a new request at the next IDLE edge.
- Requests arriving during WAIT are not acked. They wait, with payload held, until IDLE.
- busy = (state != IDLE). It rises together with dvld and falls the cycle after ddone is accepted.
- Reset asserted mid-WAIT: immediate return to reset values. Any in-flight drawer completion that arrives later is ignored in IDLE.
- Inputs are assumed synchronous to clk; no CDC.

Optional Feature:
- Macro: DRAW_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on WAIT entry and increments every WAIT cycle.
  - If it reaches TIMEOUT_CYCLES before ddone is accepted: go to IDLE, pulse timeout for one cycle, update the rr pointer as for ddone.
  - If ddone and the limit coincide, ddone wins and timeout stays 0.
- When undefined: no counter; timeout is tied 0; WAIT exits only on ddone.

Test Plan:
1. After reset, req0=1, x0=5, y0=3, data0=8'h2A at edge N.
   Required: ack0=dvld=1 in cycle N+1 with dx=5, dy=3, ddata=8'h2A, grant_id=0, busy=1. Drive ddone 100 cycles later; busy falls the next cycle.
2. req0 and req1 raised together after reset and held.
   Required: order of grants 0, 1, 0, 1. Each dvld is 2 cycles after the preceding ddone; ack pulses are never simultaneous.
3. req1 raised while in WAIT for port 0.
   Required: no ack1 until after ddone. Then ack1 with the port-1 payload held from request time.
4. ddone pulsed while IDLE, and ddone pulsed in the dvld cycle.
   Required: both ignored; state and outputs unchanged.
5. rst driven low mid-WAIT, at an arbitrary phase off the clock edge.
   Required: all outputs 0 immediately. After release, the first grant goes to port 0 when both ports request.
6. With DRAW_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold ddone.
   Required: timeout pulses once, 16 cycles after WAIT entry, and a pending req1 is then granted. Without the macro, busy stays high indefinitely.
